// File: rtl/ram_pkg.sv
// ram_pkg: geometry constants shared by the 1024x32 single-port RAM,
// its bus interface and anything that instantiates them.
package ram_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 1024;

endpackage : ram_pkg

// File: rtl/ram_1024x32_sp_if.sv
// ram_1024x32_sp_if: access bus of the single-port RAM.
//   addr      word address, shared by reads and writes
//   write_en  1 = write data_in at addr, 0 = read addr
//   data_in   write data
//   data_out  registered read / write-through data
// The master modport is the requester; the slave modport is the RAM.
import ram_pkg::*;

interface ram_1024x32_sp_if;

  logic [RAM_ADDR_W-1:0] addr;
  logic                  write_en;
  logic [RAM_DATA_W-1:0] data_in;
  logic [RAM_DATA_W-1:0] data_out;

  modport master (
    output addr,
    output write_en,
    output data_in,
    input  data_out
  );

  modport slave (
    input  addr,
    input  write_en,
    input  data_in,
    output data_out
  );

endinterface : ram_1024x32_sp_if

// File: rtl/ram_1024x32_sp.sv
// ram_1024x32_sp: 1024 x 32 single-port synchronous RAM, one-cycle read
// latency, write-first (a write also drives the written word onto data_out).
//   clk    sole clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; clears data_out only
//   bus    slave side of ram_1024x32_sp_if (addr, write_en, data_in, data_out)
// The array carries no reset so it maps onto an inferred block RAM; only
// the output register is reset.
import ram_pkg::*;

module ram_1024x32_sp (
  input logic                   clk,
  input logic                   rst_n,
  ram_1024x32_sp_if.slave       bus
);

  logic [RAM_DATA_W-1:0] mem_r [RAM_DEPTH];
  logic [RAM_DATA_W-1:0] data_out_r;

  // Array write port. Gating with rst_n blocks a write on an edge that
  // coincides with (or falls inside) reset; contents otherwise persist.
  always_ff @(posedge clk) begin
    if (rst_n && bus.write_en) begin
      mem_r[bus.addr] <= bus.data_in;
    end
  end

  // Output register: write-through on writes, array word on reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= {RAM_DATA_W{1'b0}};
    end else if (bus.write_en) begin
      data_out_r <= bus.data_in;
    end else begin
      data_out_r <= mem_r[bus.addr];
    end
  end

  assign bus.data_out = data_out_r;

endmodule : ram_1024x32_sp

// File: tb/tb_ram_1024x32_sp.sv
// Self-checking bench for ram_1024x32_sp: directed scenarios plus random
// traffic, expected data taken from a plain word-array model and checked
// by a monitor that pops a scoreboard queue one cycle after each access.
import ram_pkg::*;

module tb_ram_1024x32_sp;

  logic clk;
  logic rst_n;

  ram_1024x32_sp_if bus ();

  ram_1024x32_sp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] model [1024];   // unwritten words stay X
  int          n_total = 0;
  int          n_pass  = 0;

  // Posedges at 10, 20, ...; negedges at 5, 15, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One access, issued at a negedge; returns at the next negedge.
  task automatic op_exp(input string tag, input logic [9:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] e);
    sb_entry_t ent;
    bus.addr     = a;
    bus.write_en = w;
    bus.data_in  = d;
    ent.tag = tag;
    ent.exp = e;
    sb_q.push_back(ent);
    if (w) model[a] = d;
    @(negedge clk);
  endtask

  task automatic op(input string tag, input logic [9:0] a, input logic w, input logic [31:0] d);
    logic [31:0] e;
    e = w ? d : model[a];
    op_exp(tag, a, w, d, e);
  endtask

  // Monitor: one scoreboard entry is due after each rising edge.
  initial begin
    sb_entry_t ent;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        ent = sb_q.pop_front();
        check(ent.tag, bus.data_out, ent.exp);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    logic [31:0] j;
    // Reset for 1.5 cycles with a write attempted throughout.
    rst_n        = 1'b0;
    bus.addr     = 10'h155;
    bus.write_en = 1'b1;
    bus.data_in  = 32'hFFFF_FFFF;
    #1;
    check("reset_immediate", bus.data_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_hold", bus.data_out, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // The write attempted during reset must not have landed: word is still X.
    op("no_write_in_reset", 10'h155, 1'b0, 32'h0);

    // Full sweep with a 32-bit Johnson counter.
    j = 32'h0000_0000;
    for (int i = 0; i < 1024; i++) begin
      op("sweep_write", i[9:0], 1'b1, j);
      j = {~j[0], j[31:1]};
    end
    for (int i = 0; i < 1023; i++) begin
      op("sweep_read", i[9:0], 1'b0, 32'h0);
    end
    // Johnson period is 64; step 1023 = step 63 = 31 zeros over a single one.
    op_exp("sweep_last", 10'h3FF, 1'b0, 32'h0, 32'h0000_0001);

    // Short reset pulse between edges.
    #1 rst_n = 1'b0;
    #1 check("midreset_immediate", bus.data_out, 32'h0000_0000);
    #2 rst_n = 1'b1;
    @(negedge clk);
    op("midreset_retain", 10'h200, 1'b0, 32'h0);

    // Write-through then read back.
    op("wt_write", 10'h155, 1'b1, 32'hDEAD_BEEF);
    op("wt_read",  10'h155, 1'b0, 32'h0);

    // Alternating read-after-write at the boundaries.
    op("raw_w0",   10'h000, 1'b1, 32'h1234_5678);
    op("raw_r0",   10'h000, 1'b0, 32'h0);
    op("raw_w3ff", 10'h3FF, 1'b1, 32'h9ABC_DEF0);
    op("raw_r3ff", 10'h3FF, 1'b0, 32'h0);
    op("raw_r0b",  10'h000, 1'b0, 32'h0);

    // Overwrite and neighbours.
    op("ow_w1", 10'h0F0, 1'b1, 32'hAAAA_AAAA);
    op("ow_w2", 10'h0F0, 1'b1, 32'h5555_5555);
    op("ow_r",  10'h0F0, 1'b0, 32'h0);
    op("ow_lo", 10'h0EF, 1'b0, 32'h0);
    op("ow_hi", 10'h0F1, 1'b0, 32'h0);

    // Random traffic over a fully written array.
    for (int i = 0; i < 400; i++) begin
      op("random", 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ram_1024x32_sp

// File: doc/ram_1024x32_sp.md
# ram_1024x32_sp

Single-port synchronous RAM, 1024 words × 32 bits, with one shared address bus, a write enable, and a registered read port. It is the general-purpose on-chip word store for datapath blocks that need simple addressed storage with a fixed one-cycle read latency. The geometry is fixed.

## Interface
- No parameters. Geometry constants come from the shared package (see Structure).
- CLOCK  input  1  sole clock; every state change happens on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ADDR  input  10  word address, 0x000–0x3FF. Used for both read and write.
- WRITE_EN  input  1  1 = write DATA_IN to ADDR at this edge; 0 = read.
- DATA_IN  input  32  write data.
- DATA_OUT  output  32  registered read data.

## Operation
- Storage: 1024 × 32-bit array.
- Array contents are not affected by reset.
- Array contents are undefined (X in simulation) until written.
- Write cycle, WRITE_EN=1 at a rising edge with RESET_N=1:
  - mem[ADDR] <= DATA_IN.
  - DATA_OUT <= DATA_IN (write-first / write-through).
- Read cycle, WRITE_EN=0 at a rising edge with RESET_N=1:
  - DATA_OUT <= mem[ADDR].
  - Array is unchanged.
- Every address 0x000–0x3FF is valid. There is no out-of-range case and no wrap logic inside the block.
- No handshake. A new access is accepted on every cycle, with back-to-back reads/writes at any address mix.

## Timing
- Reset:
  - RESET_N low clears DATA_OUT to 32'h0000_0000 immediately, with no clock needed.
  - DATA_OUT stays 0 while RESET_N is low.
  - No writes occur while RESET_N is low, including an edge that coincides with reset assertion.
  - Release is taken at the first rising edge with RESET_N high.
- Read latency is 1 cycle:
  - ADDR presented before edge N gives DATA_OUT = mem[ADDR] valid after edge N.
  - That value holds until edge N+1.
- Write latency:
  - Data written at edge N is readable by a read addressed at edge N+1.
  - That read appears on DATA_OUT after edge N+1.
- Read-after-write to the same address on consecutive cycles returns the new data, with no stall and no bypass hazard.
- DATA_OUT changes only on a rising edge or on reset assertion. It is glitch-free and comes directly from a register.
- Reset mid-operation:
  - An in-flight read result is lost and DATA_OUT goes to 0.
  - Previously completed writes are retained.

## Structure
- Shared package ram_pkg holds:
  - RAM_ADDR_W = 10
  - RAM_DATA_W = 32
  - RAM_DEPTH = 1024
- The block uses these constants for port widths and array size.
- No sub-module. One array plus one output register.
- The array is coded as an inferable synchronous block RAM: no reset on the array, and reset applied only to the output register.

## Test plan
- Reset: hold RESET_N=0 for 1.5 cycles.
  - Required: DATA_OUT=0 immediately on assertion and throughout reset.
  - Required: no write occurs even with WRITE_EN=1 and DATA_IN=0xFFFFFFFF.
- Full sweep:
  - Write phase: write a 32-bit Johnson-counter pattern to ADDR 0x000..0x3FF, one per cycle. The pattern starts at 0; each step sets MSB = ~LSB and shifts the rest right.
  - Read phase: read 0x000..0x3FF back-to-back.
  - Required: each DATA_OUT, one cycle after its address, matches the pattern written there.
  - Required: 0x3FF returns the 1024th pattern value.
- Write-through: write 0xDEADBEEF at 0x155.
  - Required: DATA_OUT=0xDEADBEEF after that same edge.
  - Required: a read of 0x155 on the next cycle returns 0xDEADBEEF.
- Read-after-write, alternating:
  - Write 0x12345678@0x000, then read 0x000; write 0x9ABCDEF0@0x3FF, then read 0x3FF.
  - Required: each read returns its value one cycle later.
  - Required: the boundary addresses are independent.
- Reset mid-operation:
  - After the full sweep, pulse RESET_N low for 0.3 cycle between edges.
  - Required: DATA_OUT=0 immediately.
  - Required: a subsequent read of 0x200 returns the value written before reset.
- Overwrite: write 0xAAAAAAAA, then 0x55555555 to 0x0F0.
  - Required: a read of 0x0F0 returns 0x55555555.
  - Required: neighbours 0x0EF and 0x0F1 are unchanged.
